// File: rtl/mips_fetch_sequencer.sv
// Multicycle fetch/execute sequencer feeding the MIPS decoder.
// It owns the PC, the instruction register, branch-delay-slot tracking and halt detection.
module mips_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        extra,
  input  logic        cnt_en,
  input  logic [1:0]  pc_control,
  input  logic        branch_taken,
  input  logic [31:0] rs_value,
  output logic [1:0]  state,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] link_addr,
  output logic        active
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC1 = 2'b01,
    S_EXEC2 = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        active_q, active_d;
  logic        delay_pending_q, delay_pending_d;
  logic [31:0] delay_target_q, delay_target_d;

  logic [31:0] pc4;
  logic [31:0] br_offset;
  logic [31:0] seq_next;
  logic [31:0] target;
  logic        transfer;
  logic        commit;

  // Next-PC candidates; a pending delay-slot target always wins over pc+4.
  always_comb begin
    pc4       = pc_q + 32'd4;
    br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    seq_next  = delay_pending_q ? delay_target_q : pc4;
    target    = 32'd0;
    transfer  = 1'b0;
    case (pc_control)
      2'b00: begin
        target   = pc4 + br_offset;
        transfer = branch_taken;
      end
      2'b01: begin
        target   = {pc4[31:28], instr_q[25:0], 2'b00};
        transfer = 1'b1;
      end
      2'b10: begin
        target   = rs_value;
        transfer = 1'b1;
      end
      default: begin
        target   = 32'd0;
        transfer = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    active_d        = active_q;
    delay_pending_d = delay_pending_q;
    delay_target_d  = delay_target_q;
    commit          = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!waitrequest) begin
          instr_d = readdata;
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (!waitrequest) begin
          if (extra) begin
            state_d = S_EXEC2;
          end else if (cnt_en) begin
            commit = 1'b1;
          end
        end
      end
      S_EXEC2: begin
        if (!waitrequest) begin
          commit = 1'b1;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (commit) begin
      delay_pending_d = transfer;
      if (transfer) begin
        delay_target_d = target;
      end
      if (seq_next == HALT_ADDR) begin
        state_d  = S_HALT;
        pc_d     = HALT_ADDR;
        active_d = 1'b0;
      end else begin
        state_d = S_FETCH;
        pc_d    = seq_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_VECTOR;
      instr_q         <= 32'd0;
      active_q        <= 1'b1;
      delay_pending_q <= 1'b0;
      delay_target_q  <= 32'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      active_q        <= active_d;
      delay_pending_q <= delay_pending_d;
      delay_target_q  <= delay_target_d;
    end
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign active    = active_q;
  assign link_addr = pc_q + 32'd8;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Directed and randomized checks of mips_fetch_sequencer against an
// instruction-level reference model that tracks pending jump targets in a queue.
module tb_mips_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        extra;
  logic        cnt_en;
  logic [1:0]  pc_control;
  logic        branch_taken;
  logic [31:0] rs_value;
  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] link_addr;
  logic        active;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 fetch, 1 execute, 2 second execute, 3 halted.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_active;
  logic [31:0] m_targets[$];

  mips_fetch_sequencer dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
    .extra(extra), .cnt_en(cnt_en), .pc_control(pc_control),
    .branch_taken(branch_taken), .rs_value(rs_value), .state(state), .pc(pc),
    .instr(instr), .link_addr(link_addr), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Retire the instruction in flight: the oldest recorded target (if any)
  // decides where the next instruction comes from; a new transfer is queued.
  task automatic model_retire();
    logic [31:0] next_pc;
    logic [31:0] tgt;
    logic        jumps;
    int          imm;
    next_pc = (m_targets.size() > 0) ? m_targets.pop_front() : m_pc + 4;
    jumps = 1'b1;
    imm   = $signed(m_instr[15:0]);
    case (pc_control)
      2'd0: begin tgt = m_pc + 4 + imm * 4; jumps = branch_taken; end
      2'd1: tgt = ((m_pc + 4) & 32'hF0000000) | (m_instr[25:0] * 4);
      2'd2: tgt = rs_value;
      default: begin tgt = 0; jumps = 1'b0; end
    endcase
    if (jumps) m_targets.push_back(tgt);
    if (next_pc == 0) begin
      m_phase  = 3;
      m_pc     = 0;
      m_active = 1'b0;
    end else begin
      m_phase = 0;
      m_pc    = next_pc;
    end
  endtask

  task automatic model_clock();
    if (reset) begin
      m_phase  = 0;
      m_pc     = 32'hBFC00000;
      m_instr  = 0;
      m_active = 1'b1;
      m_targets.delete();
    end else if (!waitrequest) begin
      case (m_phase)
        0: begin m_instr = readdata; m_phase = 1; end
        1: if (extra) m_phase = 2; else if (cnt_en) model_retire();
        2: model_retire();
        default: ;
      endcase
    end
  endtask

  // One clock: inputs already driven; update model at the edge, compare just after.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("state", {30'd0, state}, m_phase[31:0]);
    check("pc", pc, m_pc);
    check("instr", instr, m_instr);
    check("active", {31'd0, active}, {31'd0, m_active});
    check("link_addr", link_addr, m_pc + 8);
    $display("t=%0t rst=%0b wr=%0b st=%0d pc=%08h instr=%08h act=%0b",
             $time, reset, waitrequest, state, pc, instr, active);
  endtask

  task automatic idle_inputs();
    reset = 0; waitrequest = 0; readdata = 0; extra = 0; cnt_en = 1;
    pc_control = 2'b11; branch_taken = 0; rs_value = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // Run one instruction end to end with no stalls.
  task automatic run_instr(input logic [31:0] word, input logic ex, input logic [1:0] pcc,
                           input logic taken, input logic [31:0] rs);
    idle_inputs();
    readdata = word;
    step();
    extra = ex; pc_control = pcc; branch_taken = taken; rs_value = rs;
    step();
    if (ex) begin
      extra = 0;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step();
    check("reset_pc", pc, 32'hBFC00000);
    reset = 0;

    // Three sequential ADDIU words.
    run_instr(32'h24010001, 0, 2'b11, 0, 0);
    run_instr(32'h24020002, 0, 2'b11, 0, 0);
    check("seq_pc2", pc, 32'hBFC00008);
    run_instr(32'h24030003, 0, 2'b11, 0, 0);

    // Stalls: 3 cycles in FETCH, 2 in EXEC1.
    waitrequest = 1; readdata = 32'h24040004;
    repeat (3) step();
    waitrequest = 0;
    step();
    waitrequest = 1;
    repeat (2) step();
    waitrequest = 0;
    step();
    check("stall_pc", pc, 32'hBFC00010);

    // LW at BFC00010 takes the EXEC2 path.
    run_instr(32'h8C050000, 1, 2'b11, 0, 0);
    check("lw_pc", pc, 32'hBFC00014);

    repeat (3) run_instr(32'h00000000, 0, 2'b11, 0, 0);
    check("beq_at", pc, 32'hBFC00020);
    run_instr(32'h10000004, 0, 2'b00, 1, 0);
    check("delay_slot_pc", pc, 32'hBFC00024);
    run_instr(32'h00000000, 0, 2'b11, 0, 0);
    check("beq_taken_pc", pc, 32'hBFC00034);

    // Not-taken variant from the same address.
    do_reset();
    repeat (8) run_instr(32'h00000000, 0, 2'b11, 0, 0);
    run_instr(32'h10000004, 0, 2'b00, 0, 0);
    run_instr(32'h00000000, 0, 2'b11, 0, 0);
    check("beq_not_taken_pc", pc, 32'hBFC00028);

    // JR to zero at BFC00040 halts after its delay slot.
    do_reset();
    repeat (16) run_instr(32'h00000000, 0, 2'b11, 0, 0);
    check("jr_at", pc, 32'hBFC00040);
    run_instr(32'h00200008, 0, 2'b10, 0, 0);
    check("jr_slot_state", {30'd0, state}, 32'd0);
    run_instr(32'h00000000, 0, 2'b11, 0, 0);
    check("halt_state", {30'd0, state}, 32'd3);
    check("halt_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      waitrequest = i[0]; readdata = $urandom; pc_control = 2'(i);
      step();
    end
    check("halt_sticky_pc", pc, 32'h0);

    // Reset in EXEC2 with a pending target discards the target.
    do_reset();
    run_instr(32'h00000000, 0, 2'b10, 0, 32'h12345678);
    readdata = 32'h8C060000;
    step();
    extra = 1;
    step();
    check("exec2_state", {30'd0, state}, 32'd2);
    do_reset();
    check("rst_mid_pc", pc, 32'hBFC00000);
    run_instr(32'h00000000, 0, 2'b11, 0, 0);
    check("after_rst_seq", pc, 32'hBFC00004);

    // Randomized traffic; the model handles everything, reset revives a halt.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0) || (m_phase == 3 && $urandom_range(0, 3) == 0);
      waitrequest  = ($urandom_range(0, 3) == 0);
      readdata     = $urandom;
      extra        = ($urandom_range(0, 3) == 0);
      cnt_en       = ($urandom_range(0, 7) != 0);
      pc_control   = 2'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
      rs_value     = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_sequencer.md
Name: mips_fetch_sequencer

Overview:
Multicycle control sequencer directly upstream of the MIPS instruction decoder. It owns the PC, the instruction register and the FETCH/EXEC1/EXEC2/HALT state that drives the decoder's state input. It commits next-PC using the decoder's PC-control and counter-enable outputs, including MIPS branch-delay-slot semantics, and detects halt on a jump to 0x0.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
HALT_ADDR, 32'h00000000, committed PC value that causes the sequencer to enter HALT.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
waitrequest  input  1  memory busy; stalls the current state.
readdata  input  32  memory read data; instruction word during FETCH.
extra  input  1  from decoder; the instruction needs EXEC2.
cnt_en  input  1  from decoder; commit PC this cycle.
pc_control  input  2  next-PC select: 00 cond branch, 01 jump imm26, 10 jump register, 11 sequential.
branch_taken  input  1  ALU branch condition, sampled with pc_control=00.
rs_value  input  32  register target for pc_control=10.
state  output  2  00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT.
pc  output  32  address of the instruction in flight; also the fetch address.
instr  output  32  instruction register.
link_addr  output  32  combinational, pc+8, for JAL/JALR/BxxAL write-back.
active  output  1  high until HALT is entered.

Behaviour:
- Reset (synchronous, overrides everything mid-operation): state=FETCH, pc=RESET_VECTOR, instr=0, active=1, delay_pending=0, delay_target=0.
- FETCH: if waitrequest, hold all state. Otherwise latch readdata into instr and go to EXEC1. The PC is unchanged.
- EXEC1: if waitrequest, hold. Otherwise:
  - extra=1: go to EXEC2 without committing.
  - extra=0: commit (cnt_en is expected high; if cnt_en=0, hold in EXEC1).
- EXEC2: if waitrequest, hold. Otherwise commit.
- HALT: terminal state with active=0. All inputs are ignored until reset.
- Commit computation:
  - pc4 = pc+4.
  - seq_next = delay_pending ? delay_target : pc4.
  - Transfer target by pc_control:
    - 00: pc4 + (sign-extended instr[15:0] << 2). This is a transfer only when branch_taken=1.
    - 01: {pc4[31:28], instr[25:0], 2'b00}.
    - 10: rs_value.
    - 11: no transfer.
  - All arithmetic is mod 2^32 and wraps silently.
  - On commit: pc <= seq_next; delay_pending <= transfer; delay_target <= target (when transfer).
- Delay slot: the instruction after a transfer always executes; the target is applied at that instruction's commit.
- Transfer inside a delay slot: the pending target is still taken at this commit. The new transfer is recorded relative to the delay-slot PC and applied after one further instruction.
- Halt: if seq_next == HALT_ADDR at commit, go to HALT (pc <= HALT_ADDR, active <= 0) instead of FETCH. A jump to 0 therefore halts only after its delay slot completes.
- Latency without waitrequest:
  - 2 cycles per instruction (FETCH, EXEC1) for non-extra instructions.
  - 3 cycles (FETCH, EXEC1, EXEC2) for extra (load) instructions.
  - Each waitrequest cycle adds exactly one cycle.
- Misaligned targets (low bits nonzero) are passed through unchanged; no exception.

Test Plan:
- Reset then 3 ADDIU words, waitrequest=0 → state 00,01,00,01,...; pc BFC00000→BFC00004→BFC00008; instr latched each FETCH.
- waitrequest high 3 cycles in FETCH, then 2 cycles in EXEC1 → state, pc and instr frozen during stalls; commit happens on the first low cycle; 7 cycles total.
- LW (extra=1) at BFC00010 → FETCH, EXEC1, EXEC2, then pc=BFC00014; no commit leaves EXEC1.
- BEQ at BFC00020, imm=0x0004, taken → delay slot BFC00024 executes, next pc=BFC00034. Same case not taken → BFC00028.
- JR with rs_value=0 at BFC00040 → delay slot BFC00044 executes; its commit enters HALT, active=0, pc=0; stays in HALT with waitrequest toggling.
- Assert reset in EXEC2 with delay_pending=1 → next cycle state=00, pc=BFC00000; pending target discarded; following instruction is sequential.
